// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl
// Owns the fetch/decode pipeline register and a per-register scoreboard of
// in-flight writes. Each cycle it decides whether the instruction held in
// decode issues to execute, stalls on a read-after-write hazard, or is
// killed by a redirect flush. A saturating counter tracks stalled cycles.

module decode_issue_ctrl #(
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_valid,
    input  logic [63:0]       f_pc,
    input  logic [31:0]       f_instr,
    output logic              f_ready,
    output logic              d_valid,
    output logic [63:0]       d_pc,
    output logic [31:0]       d_instr,
    input  logic [4:0]        d_ra1,
    input  logic [4:0]        d_ra2,
    input  logic [4:0]        d_wa,
    input  logic              d_regwrite,
    input  logic              ex_ready,
    output logic              issue_fire,
    input  logic              wb_valid,
    input  logic [4:0]        wb_wa,
    input  logic              flush,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            r_state;
    state_t            w_next_state;
    logic [63:0]       r_d_pc;
    logic [31:0]       r_d_instr;
    logic [CNT_W-1:0]  r_cnt [32];
    logic [PERF_W-1:0] r_stall_cycles;

    logic              w_busy1;
    logic              w_busy2;
    logic              w_full;
    logic              w_hazard;
    logic              w_issue;
    logic              w_f_ready;
    logic              w_accept;
    logic [31:0]       w_inc;
    logic [31:0]       w_dec;

    assign d_valid      = (r_state == S_HOLD);
    assign d_pc         = r_d_pc;
    assign d_instr      = r_d_instr;
    assign issue_fire   = w_issue;
    assign f_ready      = w_f_ready;
    assign stall_cycles = r_stall_cycles;

    // Hazard detection: a source is busy unless its last pending write retires this very cycle.
    always_comb begin
        w_busy1   = (d_ra1 != 5'd0) && (r_cnt[d_ra1] != '0) &&
                    !(wb_valid && (wb_wa == d_ra1) && (r_cnt[d_ra1] == CNT_ONE));
        w_busy2   = (d_ra2 != 5'd0) && (r_cnt[d_ra2] != '0) &&
                    !(wb_valid && (wb_wa == d_ra2) && (r_cnt[d_ra2] == CNT_ONE));
        w_full    = d_regwrite && (d_wa != 5'd0) && (r_cnt[d_wa] == CNT_MAX) &&
                    !(wb_valid && (wb_wa == d_wa));
        w_hazard  = w_busy1 || w_busy2 || w_full;
        w_issue   = d_valid && !w_hazard && ex_ready && !flush;
        w_f_ready = !flush && (!d_valid || w_issue);
        w_accept  = f_valid && w_f_ready;
    end

    // Per-register increment/decrement requests; x0 is never tracked and idle registers ignore retires.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int r = 1; r < 32; r++) begin
            w_inc[r] = w_issue && d_regwrite && (d_wa == 5'(r));
            w_dec[r] = wb_valid && (wb_wa == 5'(r)) && (r_cnt[r] != '0);
        end
    end

    // Next state of the decode slot: flush wins, then a new fetch, then a plain issue.
    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = S_EMPTY;
        end else if (w_accept) begin
            w_next_state = S_HOLD;
        end else if (w_issue) begin
            w_next_state = S_EMPTY;
        end
    end

    // Decode slot occupancy register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the fetched PC and instruction on a handshake; contents hold across a flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d_pc    <= '0;
            r_d_instr <= '0;
        end else if (w_accept) begin
            r_d_pc    <= f_pc;
            r_d_instr <= f_instr;
        end
    end

    // Scoreboard counters; simultaneous issue and retire to the same register cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (w_inc[r] && !w_dec[r]) begin
                    r_cnt[r] <= r_cnt[r] + CNT_ONE;
                end else if (w_dec[r] && !w_inc[r]) begin
                    r_cnt[r] <= r_cnt[r] - CNT_ONE;
                end
            end
        end
    end

    // Saturating count of cycles where a live instruction is held back for any reason other than flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (d_valid && !w_issue && !flush && (r_stall_cycles != {PERF_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + PERF_W'(1);
        end
    end

endmodule
